act_s2_skid: RTL
================

Name: act_s2_skid

Overview:
- Registered sequential stage placed directly downstream of the team's C2 logic-module mux.
- Computes the C2 selection (S0 = A0 & B0, S1 = A1 | B1, D00/D01/D10/D11 chosen by {S0,S1}) on incoming operands.
- Captures the result in a 2-entry skid buffer with valid/ready handshakes on both sides, giving the combinational C2 cell array a clean pipelined, back-pressurable output.
- Also models the ACT S-module synchronous clear (CLR).

Parameters:
- bits, 2, data width of each D input and of out_data.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear; flushes the buffer.
- in_valid  input  1  upstream operand set valid.
- in_ready  output  1  stage can accept this cycle.
- D00, D01, D10, D11  input  bits  C2 data inputs.
- A1, B1, A0, B0  input  1  C2 select inputs.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream accepts.
- out_data  output  bits  head-of-buffer result.
- count  output  2  occupancy, 0..2.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous): count=0, out_valid=0, out_data=0, in_ready=1, both entries cleared to 0. Outputs hold these values until the first rising clk edge after rst_n deasserts.
- Selection: sel = {S0,S1}.
  - 00 -> D00, 01 -> D01, 10 -> D10, 11 -> D11.
  - Any X/Z on the selects propagates; no default forcing.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count != 2). It depends on registered state only, never on out_ready.
- out_valid = (count != 0). out_data = head entry. Both are registered, with no combinational path from inputs.
- Latency: an operand set accepted at edge k appears on out_data with out_valid=1 after edge k, i.e. one cycle.
- Count transitions per edge:
  - push only: +1.
  - pop only: -1.
  - push & pop with count=1: head replaced by the new result, count stays 1.
  - push & pop with count=2: impossible, since in_ready=0.
  - neither: hold.
- Ordering: strict FIFO. On pop at count=2, the tail entry moves to head in the same edge.
- Full (count=2): in_ready=0. in_valid is ignored and upstream must hold its operands; no data is lost.
- Empty (count=0): out_valid=0. out_ready is ignored, and out_data holds its last value (don't-care).
- clr at an edge: count->0, out_valid->0, entries unchanged (don't-care).
  - clr beats a simultaneous push (data discarded) and a simultaneous pop.
  - in_ready is 1 in the cycle after clr.
- rst_n asserted mid-transfer: immediate return to reset state; in-flight data is lost.
- Storage: two bits-wide registers (head, tail) and a 2-bit count. Data registers are updated only when written.

Decomposition:
- Shared package:
  - sel_t, a 2-bit select encoding.
  - Constants SEL_00..SEL_11.
  - OCC_EMPTY=0, OCC_FULL=2.
- One sub-module, act_c2_sel: combinational select plus 4:1 mux, parameterised by bits. It is instantiated once at the input, ahead of the buffer.
- Buffer control stays in act_s2_skid.

Test Plan:
- Reset/select sweep, bits=2, D00=0, D01=1, D10=2, D11=3, out_ready=1:
  - Stimulus: rst_n pulse low mid-cycle, then push (A0,B0,A1,B1) = (0,0,0,0), (0,0,1,0), (1,1,0,0), (1,1,0,1) on consecutive cycles.
  - Required response during reset: outputs 0 immediately, in_ready=1.
  - Required response after reset: out_data = 0, 1, 2, 3, each one cycle after acceptance; count stays 1.
- Back-pressure:
  - Stimulus: out_ready=0, push results 1 then 2.
  - Required response: count=2, in_ready=0; a third in_valid with result 3 is held and not accepted.
  - Stimulus: raise out_ready.
  - Required response: out_data 1, then 2, then 3 in order; no loss or duplication.
- Simultaneous push/pop at count=1:
  - Stimulus: head=2, push result 3 with out_ready=1.
  - Required response: count stays 1, out_data=3 on the next cycle.
- clr priority:
  - Stimulus: count=2 with clr=1, in_valid=1, out_ready=1 in the same cycle.
  - Required response: next cycle count=0, out_valid=0, in_ready=1; the pushed value never appears.
- Async reset mid-stream:
  - Stimulus: count=1, rst_n low between edges.
  - Required response: out_valid=0 and count=0 before the next edge; normal operation resumes after release.
- Random stress, bits=4:
  - Stimulus: random valid/ready/selects for 2000 cycles.
  - Required response: scoreboard FIFO order matches the C2 model; count never exceeds 2.

Source files
------------

// File: rtl/act_s2_skid_pkg.sv
// ---------------------------------------------------------------------------
// act_s2_skid_pkg
// Shared types and constants for the ACT S2 skid stage and its C2 selector.
//   sel_t      : 2-bit select encoding {S0,S1} driving the C2 4:1 mux
//   SEL_xx     : named select codes
//   OCC_EMPTY  : buffer occupancy when nothing is held
//   OCC_FULL   : buffer occupancy when both entries are held
// ---------------------------------------------------------------------------
package act_s2_skid_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_00 = 2'b00;
  localparam sel_t SEL_01 = 2'b01;
  localparam sel_t SEL_10 = 2'b10;
  localparam sel_t SEL_11 = 2'b11;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Builds the C2 select code from the four select inputs.
  function automatic sel_t c2Sel(input logic a1, input logic b1,
                                 input logic a0, input logic b0);
    c2Sel = {a0 & b0, a1 | b1};
  endfunction

endpackage

// File: rtl/act_c2_sel.sv
// ---------------------------------------------------------------------------
// act_c2_sel
// Combinational C2 logic cell: S0 = A0 & B0, S1 = A1 | B1, and {S0,S1}
// picks one of four bits-wide data inputs.
// Ports:
//   i_d00..i_d11 : data inputs (bits wide)
//   i_a1, i_b1   : OR-pair selecting the low select bit S1
//   i_a0, i_b0   : AND-pair selecting the high select bit S0
//   o_result     : selected data (bits wide)
// ---------------------------------------------------------------------------
module act_c2_sel
  import act_s2_skid_pkg::*;
#(
  parameter int bits = 2
) (
  input  logic [bits-1:0] i_d00,
  input  logic [bits-1:0] i_d01,
  input  logic [bits-1:0] i_d10,
  input  logic [bits-1:0] i_d11,
  input  logic            i_a1,
  input  logic            i_b1,
  input  logic            i_a0,
  input  logic            i_b0,
  output logic [bits-1:0] o_result
);

  sel_t w_sel;

  assign w_sel = c2Sel(i_a1, i_b1, i_a0, i_b0);

  // Nested ternaries rather than a case statement so that an unknown select
  // bit merges the candidate inputs into X instead of being forced to a
  // default leg.
  assign o_result = w_sel[1] ? (w_sel[0] ? i_d11 : i_d10)
                             : (w_sel[0] ? i_d01 : i_d00);

endmodule

// File: rtl/act_s2_skid.sv
// ---------------------------------------------------------------------------
// act_s2_skid
// Registered stage behind the C2 mux: the C2 result of each accepted operand
// set is captured in a 2-entry skid buffer (head, tail) with valid/ready
// handshakes on both sides, plus a synchronous clear.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   clr              : synchronous flush of the buffer
//   in_valid/in_ready: upstream handshake (in_ready from state only)
//   D00..D11         : C2 data inputs (bits wide)
//   A1, B1, A0, B0   : C2 select inputs
//   out_valid        : head entry is valid
//   out_ready        : downstream accepts the head this cycle
//   out_data         : head entry (bits wide)
//   count            : occupancy 0..2
// ---------------------------------------------------------------------------
module act_s2_skid
  import act_s2_skid_pkg::*;
#(
  parameter int bits = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bits-1:0] D00,
  input  logic [bits-1:0] D01,
  input  logic [bits-1:0] D10,
  input  logic [bits-1:0] D11,
  input  logic            A1,
  input  logic            B1,
  input  logic            A0,
  input  logic            B0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bits-1:0] out_data,
  output logic [1:0]      count
);

  logic [bits-1:0] r_head;
  logic [bits-1:0] r_tail;
  logic [1:0]      r_count;

  logic [bits-1:0] w_result;
  logic            w_inReady;
  logic            w_outValid;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_countNext;
  logic            w_headWe;
  logic [bits-1:0] w_headNext;
  logic            w_tailWe;

  act_c2_sel #(
    .bits(bits)
  ) u_c2Sel (
    .i_d00   (D00),
    .i_d01   (D01),
    .i_d10   (D10),
    .i_d11   (D11),
    .i_a1    (A1),
    .i_b1    (B1),
    .i_a0    (A0),
    .i_b0    (B0),
    .o_result(w_result)
  );

  // Handshake flags come purely from the registered occupancy, so neither
  // ready nor valid has a combinational path from the opposite side.
  assign w_inReady  = (r_count != OCC_FULL);
  assign w_outValid = (r_count != OCC_EMPTY);
  assign w_push     = in_valid & w_inReady;
  assign w_pop      = w_outValid & out_ready;

  // Next-state decode for occupancy and entry writes. A simultaneous push and
  // pop can only happen with one entry held, so the head is simply replaced.
  // On a pop from full the tail slides into the head to keep FIFO order.
  // clr wins over everything and leaves the entries untouched.
  always_comb begin
    w_countNext = r_count;
    w_headWe    = 1'b0;
    w_headNext  = w_result;
    w_tailWe    = 1'b0;
    if (clr) begin
      w_countNext = OCC_EMPTY;
    end else if (w_push && w_pop) begin
      w_headWe   = 1'b1;
      w_headNext = w_result;
    end else if (w_push) begin
      if (r_count == OCC_EMPTY) begin
        w_headWe = 1'b1;
      end else begin
        w_tailWe = 1'b1;
      end
      w_countNext = r_count + 2'd1;
    end else if (w_pop) begin
      if (r_count == OCC_FULL) begin
        w_headWe   = 1'b1;
        w_headNext = r_tail;
      end
      w_countNext = r_count - 2'd1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= OCC_EMPTY;
    end else begin
      r_count <= w_countNext;
    end
  end

  // Head entry; written only on capture or tail promotion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
    end else if (w_headWe) begin
      r_head <= w_headNext;
    end
  end

  // Tail entry; written only when a push lands behind a held head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail <= '0;
    end else if (w_tailWe) begin
      r_tail <= w_result;
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = w_outValid;
  assign out_data  = r_head;
  assign count     = r_count;

endmodule
